// File: rtl/mul_int8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential shift-and-add multiplier.
// master drives operands and result acceptance; slave is the multiplier.
interface mul_int8_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mul_int8_seq_ctrl.sv
// Iterative shift-and-add multiplier: one partial product per clock, WIDTH cycles
// per operation, producing the lower WIDTH bits of a*b.
module mul_int8_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul_int8_seq_ctrl_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             accept;

    // Popping a finished result frees the controller in the same cycle.
    assign bus.in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.p         = acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand_reg  <= bus.a;
                        mplier_reg <= bus.b;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end else if (state_reg == DONE && bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // Carry out of the top bit is dropped: result is mod 2^WIDTH.
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_int8_seq_ctrl.sv
// Directed bench for the sequential multiplier: latency, handshakes, stall,
// back-to-back issue, ignored mid-run input and asynchronous abort.
module tb_mul_int8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mul_int8_seq_ctrl_if #(.WIDTH(8)) bus ();

    mul_int8_seq_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; caller guarantees in_ready.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        #1;
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
    endtask

    // Counts edges until out_valid; optionally pulses a stray operand mid-run.
    task automatic wait_result(input string tag, input logic [7:0] exp_p, input bit glitch);
        int n = 0;
        int bc = 0;
        while (!bus.out_valid && n < 20) begin
            if (bus.busy) bc++;
            if (glitch && n == 3) begin
                bus.in_valid = 1'b1;
                bus.a = 8'd1;
                bus.b = 8'd1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_p"}, 32'(bus.p), 32'(exp_p));
        $display("op %s: p=%02h expected=%02h after %0d cycles", tag, bus.p, exp_p, n);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_pop", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_pop", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_p", 32'(bus.p), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        start_op(8'd3, 8'd5);
        wait_result("3x5", 8'd15, 1'b0);
        pop();

        start_op(8'hFF, 8'hFF);
        wait_result("ffxff", 8'h01, 1'b0);
        pop();
        start_op(8'd100, 8'd3);
        wait_result("100x3", 8'h2C, 1'b0);
        pop();
        start_op(8'hFE, 8'h03);
        wait_result("m2x3", 8'hFA, 1'b0);
        pop();
        start_op(8'd16, 8'd16);
        wait_result("16x16", 8'h00, 1'b0);
        pop();

        // Zero multiplier still takes the full run; then stall the consumer.
        start_op(8'h37, 8'h00);
        wait_result("37x0", 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_p", 32'(bus.p), 32'd0);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end

        // Back-to-back: pop and accept on the same edge.
        bus.out_ready = 1'b1;
        start_op(8'd7, 8'd9);
        check("b2b_out_valid_dropped", 32'(bus.out_valid), 32'd0);
        wait_result("7x9", 8'd63, 1'b0);
        pop();

        // Stray operand during RUN must be ignored.
        start_op(8'd3, 8'd5);
        wait_result("3x5_glitch", 8'd15, 1'b1);
        pop();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_extra_result", 32'(bus.out_valid), 32'd0);
        end

        // Asynchronous abort in the middle of a run.
        start_op(8'd3, 8'd5);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_p", 32'(bus.p), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
            check("abort_idle", 32'(bus.busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_int8_seq_ctrl.md
Name: mul_int8_seq_ctrl

Overview:
- Iterative shift-and-add controller that computes the lower WIDTH bits of an unsigned integer product A*B, one partial product per clock.
- Owns a single WIDTH-bit adder and sequences it over WIDTH cycles, in place of the fully unrolled adder chain.
- Valid/ready handshakes on input and output; used where PIM benchmarks trade latency for area.
- The result equals the combinational truncated product bit-for-bit, so it is valid for two's-complement operands too.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  controller can accept operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  p holds a completed result
- out_ready  input  1  consumer accepts p this cycle
- p  output  WIDTH  lower WIDTH bits of a*b
- busy  output  1  high while in RUN

Behaviour:
- Registers:
  - mcand (WIDTH)
  - mplier (WIDTH)
  - acc (WIDTH)
  - cnt (ceil(log2(WIDTH+1)) bits)
  - state in {IDLE, RUN, DONE}
- Reset (rst_n=0, asynchronous):
  - state=IDLE; mcand=mplier=acc=cnt=0
  - out_valid=0, busy=0, p=0, in_ready=1 (once reset is released)
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready; no path from in_valid.
- Accept occurs on an edge where in_valid & in_ready:
  - mcand<=a, mplier<=b, acc<=0, cnt<=0, state<=RUN
  - a/b are sampled only on that edge; later changes are ignored.
- RUN, each edge:
  - if mplier[0], acc <= acc + mcand, carry-out discarded (mod 2^WIDTH)
  - mcand <= mcand<<1 (zero fill); mplier <= mplier>>1; cnt <= cnt+1
  - when cnt==WIDTH-1 on this edge, state<=DONE after the final add
- RUN lasts exactly WIDTH cycles. out_valid rises exactly WIDTH edges after the accept edge. There is no early termination, even when mplier==0.
- in_valid is ignored in RUN (in_ready=0).
- DONE:
  - out_valid=1; p=acc, held stable while out_valid & !out_ready
  - out_ready=1 with in_valid=0: state<=IDLE, out_valid falls next cycle
  - out_ready=1 with in_valid=1: pop and accept on the same edge, state<=RUN (back-to-back). Sustained throughput is one result per WIDTH+1 cycles.
- p = acc in all states. p is only meaningful while out_valid=1 and may change during RUN.
- busy = (state==RUN).
- cnt never exceeds WIDTH-1 in RUN and holds its value outside RUN.
- Reset asserted mid-RUN or in DONE aborts immediately: the result is lost and no out_valid pulse is produced after release.
- Unreachable state encodings transition to IDLE.

Test Plan:
- Reset, then a=3, b=5, one-cycle in_valid -> in_ready drops next cycle; busy high 8 cycles; out_valid rises exactly 8 edges after accept with p=15.
- a=8'hFF, b=8'hFF -> p=8'h01. Then a=100, b=3 -> p=8'h2C. Then a=8'hFE (-2), b=8'h03 -> p=8'hFA (-6). Then a=16, b=16 -> p=8'h00.
- a=0x37, b=0: result p=0 after the full 8 cycles. Then out_ready held low 5 cycles after out_valid -> p and out_valid stable, in_ready=0 throughout.
- Back-to-back: in DONE with out_ready=1, in_valid=1, a=7, b=9 -> first result popped and new op accepted on the same edge; second out_valid 8 edges later with p=63.
- in_valid pulsed with a=1, b=1 during RUN of 3*5 -> ignored; result remains 15 and no extra result appears.
- rst_n low for 1 cycle at RUN cycle 4 of 3*5 -> outputs take reset values immediately; after release, in_ready=1 and no out_valid until a new accept.
